// File: rtl/toggle_event_decoder.sv
// Decodes a toggle-encoded asynchronous event line into single-cycle strobes,
// keeps a bounded count of undelivered events and a wrapping total event count.
module toggle_event_decoder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned DEPTH       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tgl_in,
  input  logic             evt_ready,
  input  logic             cnt_clr,
  output logic             evt_pulse,
  output logic             evt_valid,
  output logic [3:0]       pending,
  output logic [CNT_W-1:0] evt_count,
  output logic             overflow
);

  typedef enum logic [0:0] {StPrime, StArmed} state_e;

  localparam logic [2:0]       PrimeLast = 3'(SYNC_STAGES);
  localparam logic [3:0]       DepthMax  = 4'(DEPTH);
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

  state_e                 state_q;
  logic [2:0]             prime_cnt_q;
  logic [SYNC_STAGES-1:0] sync_chain_q;
  logic                   sync_q;
  logic                   ref_q;

  logic       det;
  logic       hs;
  logic       full;
  logic       drop;
  logic [3:0] pending_d;

  assign sync_q = sync_chain_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_chain_q <= '0;
    end else begin
      sync_chain_q <= {sync_chain_q[SYNC_STAGES-2:0], tgl_in};
    end
  end

  always_comb begin
    det  = (state_q == StArmed) && (sync_q != ref_q);
    hs   = evt_valid && evt_ready;
    full = (pending == DepthMax);
    drop = det && !hs && full;
    pending_d = pending;
    case ({det, hs})
      2'b10:   pending_d = full ? pending : pending + 4'd1;
      2'b01:   pending_d = pending - 4'd1;
      default: pending_d = pending;
    endcase
  end

  // Priming lets the synchronizer flush its reset value so the level present
  // at reset release is adopted as the reference rather than seen as an event.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StPrime;
      prime_cnt_q <= '0;
      ref_q       <= 1'b0;
      evt_pulse   <= 1'b0;
      evt_valid   <= 1'b0;
      pending     <= '0;
      evt_count   <= '0;
      overflow    <= 1'b0;
    end else begin
      ref_q     <= sync_q;
      evt_pulse <= det;
      pending   <= pending_d;
      evt_valid <= (pending_d != 4'd0);

      case (state_q)
        StPrime: begin
          if (prime_cnt_q == PrimeLast) begin
            state_q <= StArmed;
          end else begin
            prime_cnt_q <= prime_cnt_q + 3'd1;
          end
        end
        default: state_q <= StArmed;
      endcase

      if (cnt_clr) begin
        evt_count <= '0;
        overflow  <= 1'b0;
      end else begin
        if (det) begin
          evt_count <= evt_count + CntOne;
        end
        if (drop) begin
          overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_toggle_event_decoder.sv
// Scoreboard bench: a cycle-level event model predicts each strobe and the
// queue/counter state it should carry; a negedge monitor checks every strobe.
module tb_toggle_event_decoder;

  localparam int S  = 2;
  localparam int CW = 8;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          tgl_in;
  logic          evt_ready;
  logic          cnt_clr;
  logic          evt_pulse;
  logic          evt_valid;
  logic [3:0]    pending;
  logic [CW-1:0] evt_count;
  logic          overflow;

  toggle_event_decoder #(
    .SYNC_STAGES(S),
    .CNT_W      (CW),
    .DEPTH      (D)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tgl_in   (tgl_in),
    .evt_ready(evt_ready),
    .cnt_clr  (cnt_clr),
    .evt_pulse(evt_pulse),
    .evt_valid(evt_valid),
    .pending  (pending),
    .evt_count(evt_count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int cnt;
    int pend;
    int ovf;
  } exp_t;

  exp_t exp_q[$];
  int   sched[$];
  int   cyc;
  int   m_pend;
  int   m_cnt;
  int   m_ovf;
  int   n_chk;
  int   n_pass;

  function automatic void check(string name, int got, int want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, got, want, cyc);
  endfunction

  function automatic void clear_model();
    m_pend = 0;
    m_cnt  = 0;
    m_ovf  = 0;
    exp_q.delete();
    sched.delete();
  endfunction

  task automatic check_state(string name);
    check({name, " pending"}, int'(pending), m_pend);
    check({name, " count"}, int'(evt_count), m_cnt);
    check({name, " overflow"}, int'(overflow), m_ovf);
    check({name, " valid"}, int'(evt_valid), (m_pend != 0) ? 1 : 0);
  endtask

  // Applies inputs for the next edge, advances the model over that edge, then waits it out.
  task automatic tick(input bit rdy, input bit clr);
    bit det;
    bit hs;
    bit drop;
    evt_ready = rdy;
    cnt_clr   = clr;
    det  = 1'b0;
    drop = 1'b0;
    if (sched.size() > 0 && sched[0] == cyc + 1) begin
      det = 1'b1;
      void'(sched.pop_front());
    end
    hs = (m_pend > 0) && rdy;
    if (det && !hs) begin
      if (m_pend == D) drop = 1'b1;
      else m_pend++;
    end else if (!det && hs) begin
      m_pend--;
    end
    if (det) m_cnt = (m_cnt + 1) % (1 << CW);
    if (clr) begin
      m_cnt = 0;
      m_ovf = 0;
    end else if (drop) begin
      m_ovf = 1;
    end
    if (det) exp_q.push_back('{cyc: cyc + 1, cnt: m_cnt, pend: m_pend, ovf: m_ovf});
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic ticks(input int n, input bit rdy);
    for (int i = 0; i < n; i++) tick(rdy, 1'b0);
  endtask

  // A level change first sampled at the next edge is detected S edges after that.
  task automatic toggle();
    tgl_in = ~tgl_in;
    sched.push_back(cyc + 1 + S);
  endtask

  task automatic do_reset(input logic level);
    #2;
    reset = 1'b0;
    #1;
    check("rst pulse", int'(evt_pulse), 0);
    check("rst pending", int'(pending), 0);
    check("rst count", int'(evt_count), 0);
    check("rst overflow", int'(overflow), 0);
    check("rst valid", int'(evt_valid), 0);
    clear_model();
    tgl_in    = level;
    evt_ready = 1'b0;
    cnt_clr   = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    @(posedge clk);
    #1;
    cyc++;
    reset = 1'b1;
  endtask

  always @(negedge clk) begin
    if (reset && evt_pulse) begin
      if (exp_q.size() == 0) begin
        check("unexpected pulse", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse edge", cyc, e.cyc);
        check("pulse count", int'(evt_count), e.cnt);
        check("pulse pending", int'(pending), e.pend);
        check("pulse overflow", int'(overflow), e.ovf);
      end
    end
  end

  initial begin
    bit r;
    bit c;
    int pend_before;
    n_chk     = 0;
    n_pass    = 0;
    cyc       = 0;
    reset     = 1'b0;
    tgl_in    = 1'b1;
    evt_ready = 1'b0;
    cnt_clr   = 1'b0;
    clear_model();
    @(posedge clk);
    #1;
    cyc++;
    @(posedge clk);
    #1;
    cyc++;
    check("init pending", int'(pending), 0);
    check("init pulse", int'(evt_pulse), 0);
    reset = 1'b1;

    // Level 1 held through reset release must not produce an event.
    ticks(10, 1'b0);
    check("held1 count", int'(evt_count), 0);
    check("held1 pending", int'(pending), 0);
    check_state("held1");

    // Single 0->1 toggle after priming.
    do_reset(1'b0);
    ticks(10, 1'b0);
    toggle();
    ticks(S + 2, 1'b0);
    check("single count", int'(evt_count), 1);
    check("single pending", int'(pending), 1);
    check("single valid", int'(evt_valid), 1);

    // Six more toggles with no consumer: saturate and overflow, then drain.
    for (int i = 0; i < 6; i++) begin
      toggle();
      ticks(8, 1'b0);
    end
    check("sat pending", int'(pending), 4);
    check("sat count", int'(evt_count), 7);
    check("sat overflow", int'(overflow), 1);
    check_state("sat");
    ticks(4, 1'b1);
    check("drain pending", int'(pending), 0);
    check("drain valid", int'(evt_valid), 0);

    // Full queue with an event landing on a handshake edge.
    tick(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      toggle();
      ticks(4, 1'b0);
    end
    check("full pending", int'(pending), 4);
    toggle();
    ticks(S, 1'b0);
    tick(1'b1, 1'b0);
    ticks(2, 1'b0);
    check("coinc pending", int'(pending), 4);
    check("coinc overflow", int'(overflow), 0);
    check_state("coinc");
    ticks(6, 1'b1);

    // 256 events wrap the 8-bit counter back to zero.
    tick(1'b0, 1'b1);
    for (int i = 0; i < 256; i++) begin
      toggle();
      for (int j = 0; j < S + 1; j++) begin
        r = 1'($urandom_range(0, 1));
        tick(r, 1'b0);
      end
    end
    ticks(4, 1'b0);
    check("wrap count", int'(evt_count), 0);
    check_state("wrap");

    // Clear on the same edge as a detection.
    ticks(6, 1'b1);
    pend_before = m_pend;
    toggle();
    ticks(S, 1'b0);
    tick(1'b0, 1'b1);
    ticks(2, 1'b0);
    check("clr count", int'(evt_count), 0);
    check("clr overflow", int'(overflow), 0);
    check("clr pending", int'(pending), pend_before + 1);

    // Randomized spacing, consumer and clears.
    for (int i = 0; i < 80; i++) begin
      int gap;
      toggle();
      gap = $urandom_range(S + 1, 9);
      for (int j = 0; j < gap; j++) begin
        r = 1'($urandom_range(0, 1));
        c = ($urandom_range(0, 15) == 0);
        tick(r, c);
      end
    end
    ticks(4, 1'b0);
    check_state("random");

    // Reset mid-stream with three events pending and one in flight.
    ticks(8, 1'b1);
    for (int i = 0; i < 3; i++) begin
      toggle();
      ticks(4, 1'b0);
    end
    check("pre-rst pending", int'(pending), 3);
    toggle();
    tick(1'b0, 1'b0);
    do_reset(1'b1);
    ticks(12, 1'b0);
    check("post-rst count", int'(evt_count), 0);
    check_state("post-rst");

    check("missed pulses", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
